// File: rtl/fsk_frame_modulator.sv
// Framed FSK transmitter: serialises words as async frames (start, data LSB
// first, optional parity, stop) and renders each bit as a phase-continuous
// square-wave tone (mark = 1, space = 0).
module fsk_frame_modulator #(
  parameter int HALF_MARK  = 4,
  parameter int HALF_SPACE = 8,
  parameter int BIT_CYCLES = 64,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int IDLE_TONE  = 1
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 signal_out,
  output logic                 tone_sel,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int HALF_MAX = (HALF_MARK > HALF_SPACE) ? HALF_MARK : HALF_SPACE;
  localparam int HW = $clog2(HALF_MAX - 1) + 1;
  localparam int TW = $clog2(BIT_CYCLES - 1) + 1;
  localparam int CW = $clog2(DATA_BITS) + 1;

  localparam logic [HW-1:0] HM_LD  = HW'(HALF_MARK - 1);
  localparam logic [HW-1:0] HS_LD  = HW'(HALF_SPACE - 1);
  localparam logic [TW-1:0] BIT_LD = TW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_n;
  logic [TW-1:0]        bit_tmr, tmr_n;
  logic [CW-1:0]        bit_cnt, cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_n;
  logic                 tone_n;
  logic [HW-1:0]        half_cnt;
  logic                 bit_end, last_stop, take;

  assign bit_end    = (state != IDLE) && (bit_tmr == '0);
  assign last_stop  = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
  assign data_ready = ((state == IDLE) || last_stop) && !rst;
  assign take       = data_valid && data_ready;
  assign busy       = (state != IDLE);
  assign frame_done = last_stop;

  // Frame sequencing: next state, bit timer, bit counter, shift register and
  // the bit value to put on the line from the next edge onwards.
  always_comb begin
    state_n = state;
    tmr_n   = bit_tmr;
    cnt_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_bit;
    tone_n  = tone_sel;
    if (state != IDLE) tmr_n = bit_tmr - TW'(1);
    if (take) begin
      // Also covers a back-to-back word accepted in the final stop cycle.
      state_n = START;
      tmr_n   = BIT_LD;
      cnt_n   = '0;
      shreg_n = data_in;
      par_n   = (^data_in) ^ ODD_PAR;
      tone_n  = 1'b0;
    end else if (bit_end) begin
      tmr_n = BIT_LD;
      cnt_n = '0;
      case (state)
        START: begin
          state_n = DATA;
          tone_n  = shreg[0];
        end
        DATA: begin
          if (bit_cnt == DATA_LAST) begin
            if (PARITY != 0) begin
              state_n = PAR;
              tone_n  = par_bit;
            end else begin
              state_n = STOP;
              tone_n  = 1'b1;
            end
          end else begin
            cnt_n   = bit_cnt + CW'(1);
            shreg_n = shreg >> 1;
            tone_n  = shreg[1];
          end
        end
        PAR: begin
          state_n = STOP;
          tone_n  = 1'b1;
        end
        STOP: begin
          if (bit_cnt == STOP_LAST) begin
            state_n = IDLE;
            tmr_n   = '0;
            tone_n  = 1'b1;
          end else begin
            cnt_n = bit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Frame state registers.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state    <= IDLE;
      bit_tmr  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tone_sel <= 1'b1;
    end else begin
      state    <= state_n;
      bit_tmr  <= tmr_n;
      bit_cnt  <= cnt_n;
      shreg    <= shreg_n;
      par_bit  <= par_n;
      tone_sel <= tone_n;
    end
  end

  // Tone generator: the half-period is chosen only at a toggle, so a tone
  // change never truncates the half-period in flight. With a quiet idle the
  // line is parked high (also while leaving and entering idle) with the
  // counter primed so the first space toggle lands a full half-period in.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      signal_out <= 1'b1;
      half_cnt   <= HM_LD;
    end else if ((IDLE_TONE == 0) && ((state == IDLE) || (state_n == IDLE))) begin
      signal_out <= 1'b1;
      half_cnt   <= HS_LD;
    end else if (half_cnt == '0) begin
      signal_out <= ~signal_out;
      half_cnt   <= tone_sel ? HM_LD : HS_LD;
    end else begin
      half_cnt <= half_cnt - HW'(1);
    end
  end

endmodule

// File: tb/tb_fsk_frame_modulator.sv
// Bench for fsk_frame_modulator: two instances (A: even parity, mark idle tone,
// short tones; B: odd parity, two stops, quiet idle). Accepted words are queued
// with their handshake cycle; a negedge monitor rebuilds each frame's bit
// sequence from the word and checks the outputs cycle by cycle.
module tb_fsk_frame_modulator;

  localparam int BCYC = 16;

  typedef struct {
    logic [7:0] w;
    int         t;
  } exp_t;

  logic       sysclk;
  logic       rst;
  logic [1:0] vld, rdy, sig, tone, bsy, fdn;
  logic [7:0] din [2];

  int   cyc   = 0;
  logic rst_q = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t sb_q [2][$];
  exp_t cur  [2];
  logic act [2];
  logic was_act [2];
  logic from_idle [2];
  logic sig_prev [2];
  logic tone_prev [2];
  logic run_ok [2];
  int   run_len [2];
  int   run_exp [2];

  fsk_frame_modulator #(
    .HALF_MARK(2), .HALF_SPACE(5), .BIT_CYCLES(BCYC), .DATA_BITS(8),
    .STOP_BITS(1), .PARITY(1), .IDLE_TONE(1)
  ) u_dut_a (
    .sysclk(sysclk), .rst(rst), .data_in(din[0]), .data_valid(vld[0]),
    .data_ready(rdy[0]), .signal_out(sig[0]), .tone_sel(tone[0]),
    .busy(bsy[0]), .frame_done(fdn[0])
  );

  fsk_frame_modulator #(
    .HALF_MARK(4), .HALF_SPACE(8), .BIT_CYCLES(BCYC), .DATA_BITS(8),
    .STOP_BITS(2), .PARITY(2), .IDLE_TONE(0)
  ) u_dut_b (
    .sysclk(sysclk), .rst(rst), .data_in(din[1]), .data_valid(vld[1]),
    .data_ready(rdy[1]), .signal_out(sig[1]), .tone_sel(tone[1]),
    .busy(bsy[1]), .frame_done(fdn[1])
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic int par_of(input int i);  return (i == 0) ? 1 : 2; endfunction
  function automatic int stop_of(input int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int hm_of(input int i);   return (i == 0) ? 2 : 4; endfunction
  function automatic int hs_of(input int i);   return (i == 0) ? 5 : 8; endfunction
  function automatic int flen(input int i);
    return (1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i)) * BCYC;
  endfunction

  // Line value of frame bit idx for word w.
  function automatic logic exp_bit(input logic [7:0] w, input int par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    if (idx == 9 && par != 0) return (par == 1) ? (^w) : ~(^w);
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, i, cyc, got, want);
    end
  endtask

  // Reference model + monitor.
  always @(negedge sysclk) begin : mon
    int j;
    int f;
    logic [2:0] exp3;
    logic er;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      f = flen(i);
      j = 0;
      if (rst_q) begin
        act[i] = 1'b0;
        sb_q[i].delete();
      end else begin
        if (act[i] && (cyc - cur[i].t + 1) > f) act[i] = 1'b0;
        if (!act[i] && sb_q[i].size() > 0 && sb_q[i][0].t == cyc) begin
          cur[i]       = sb_q[i].pop_front();
          act[i]       = 1'b1;
          from_idle[i] = !was_act[i];
        end
      end
      if (act[i]) begin
        j    = cyc - cur[i].t + 1;
        exp3 = {1'b1, exp_bit(cur[i].w, par_of(i), (j - 1) / BCYC), (j == f)};
      end else begin
        exp3 = 3'b010;
      end
      chk("busy_tone_done", i, {29'd0, bsy[i], tone[i], fdn[i]}, {29'd0, exp3});
      er = !rst && (!act[i] || j == f);
      chk("data_ready", i, {31'd0, rdy[i]}, {31'd0, er});
      if (vld[i] && er) begin
        e.w = din[i];
        e.t = cyc + 1;
        sb_q[i].push_back(e);
      end
      if (rst_q) begin
        chk("sig_reset", i, {31'd0, sig[i]}, 32'd1);
        run_ok[i] = 1'b0;
      end else begin
        if (sig[i] !== sig_prev[i]) begin
          if (run_ok[i] && i == 0) chk("run_len", i, run_len[i], run_exp[i]);
          run_exp[i] = tone_prev[i] ? hm_of(i) : hs_of(i);
          run_len[i] = 1;
          run_ok[i]  = 1'b1;
        end else begin
          run_len[i]++;
        end
        if (i == 1 && !act[i]) chk("idle_level", i, {31'd0, sig[i]}, 32'd1);
        if (i == 1 && act[i] && from_idle[i] && j == hs_of(1))
          chk("pre_first_fall", i, {31'd0, sig[i]}, 32'd1);
        if (i == 1 && act[i] && from_idle[i] && j == hs_of(1) + 1)
          chk("first_fall", i, {31'd0, sig[i]}, 32'd0);
      end
      sig_prev[i]  = sig[i];
      tone_prev[i] = tone[i];
      was_act[i]   = act[i];
    end
  end

  // Offer a word and hold it until accepted (bounded).
  task automatic send(input int i, input logic [7:0] w);
    int n;
    n = 0;
    vld[i] = 1'b1;
    din[i] = w;
    do begin
      @(negedge sysclk);
      n++;
    end while (!rdy[i] && n < 2000);
    if (!rdy[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout dut%0d cyc=%0d got=not_ready want=ready", i, cyc);
    end
    @(posedge sysclk);
    #1 vld[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (bsy[i] && n < 2000);
    if (bsy[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout dut%0d cyc=%0d got=busy want=idle", i, cyc);
    end
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; was_act[i] = 1'b0; from_idle[i] = 1'b0;
      sig_prev[i] = 1'b1; tone_prev[i] = 1'b1; run_ok[i] = 1'b0;
      run_len[i] = 0; run_exp[i] = 0; din[i] = 8'h00;
    end
    rst = 1'b1;
    vld = 2'b00;
    repeat (3) @(posedge sysclk);
    #1 rst = 1'b0;
    repeat (4) @(posedge sysclk);
    #1;

    // Single frames with fixed words.
    send(0, 8'hA5);
    wait_idle(0);
    send(1, 8'h01);
    wait_idle(1);

    // Random words, random gaps.
    for (int k = 0; k < 3; k++) begin
      send(1, 8'($urandom));
      repeat ($urandom_range(0, 10)) @(posedge sysclk);
      #1;
    end
    wait_idle(1);
    for (int k = 0; k < 6; k++) begin
      send(0, 8'($urandom));
      repeat ($urandom_range(0, 20)) @(posedge sysclk);
      #1;
    end
    wait_idle(0);

    // Back-to-back: valid held across the frame_done cycle.
    send(0, 8'h00);
    send(0, 8'hFF);
    wait_idle(0);

    // Valid pulsed mid-frame must be ignored.
    send(0, 8'($urandom));
    repeat (30) @(posedge sysclk);
    #1 vld[0] = 1'b1;
    din[0] = 8'h3C;
    @(posedge sysclk);
    #1 vld[0] = 1'b0;
    din[0] = 8'h00;
    send(0, 8'h5A);
    wait_idle(0);

    // Reset mid-frame on both instances.
    send(0, 8'($urandom));
    send(1, 8'($urandom));
    repeat (40) @(posedge sysclk);
    #1 rst = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 rst = 1'b0;
    repeat (5) @(posedge sysclk);
    #1;
    send(0, 8'($urandom));
    send(1, 8'($urandom));
    wait_idle(0);
    wait_idle(1);
    repeat (10) @(posedge sysclk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsk_frame_modulator.md
# fsk_frame_modulator

Parametrised, framed FSK transmitter. Accepts parallel data words over a valid/ready handshake. Serialises each word as an asynchronous frame (start bit, data bits LSB first, optional parity, stop bits) and emits each bit as a phase-continuous square-wave tone: mark for 1, space for 0. Tone half-periods and bit period are set by parameters, so the block does not need the external baud-rate generator. It sits between the host data path and the line driver.

## Interface
Parameters:
- `HALF_MARK`, default 4: mark-tone half-period in `sysclk` cycles (≥1).
- `HALF_SPACE`, default 8: space-tone half-period in `sysclk` cycles (≥1).
- `BIT_CYCLES`, default 64: `sysclk` cycles per bit (≥2).
- `DATA_BITS`, default 8: data bits per frame (5–9).
- `STOP_BITS`, default 1: stop bits per frame (1 or 2).
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `IDLE_TONE`, default 1: 1 = mark tone runs while idle; 0 = `signal_out` held 1 while idle.

Ports:
- `sysclk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `data_in` input `DATA_BITS`: word to send; sampled on handshake.
- `data_valid` input 1: word offered.
- `data_ready` output 1: block can accept a word; transfer occurs when valid && ready.
- `signal_out` output 1: FSK line output.
- `tone_sel` output 1: bit currently being sent (1 = mark); 1 when idle.
- `busy` output 1: frame in progress.
- `frame_done` output 1: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- FSM states: IDLE, START, DATA, PAR, STOP.
- Each non-IDLE state bit lasts exactly `BIT_CYCLES` cycles. A bit timer loads `BIT_CYCLES-1` and counts down to 0.
- Transitions:
  - IDLE→START on handshake; `data_in` latched into the shift register.
  - START→DATA.
  - DATA repeats for `DATA_BITS` bits, shifting LSB first; then → PAR if `PARITY`≠0, else → STOP.
  - PAR→STOP.
  - STOP repeats for `STOP_BITS` bits; then → IDLE, or → START if a handshake occurs in that last cycle.
- Bit values: START = 0; DATA = shift register LSB; PAR = XOR of latched word (even), or its inverse (odd); STOP = 1.
- `tone_sel` is registered. It updates on the same edge the state/bit changes.
- Tone generator:
  - Half-period counter counts down to 0.
  - At 0 it toggles `signal_out` and reloads `HALF_MARK-1` or `HALF_SPACE-1` according to `tone_sel` at that instant.
  - Tone changes therefore take effect only at the next toggle: phase-continuous, no truncated half-periods.
- `IDLE_TONE`=0:
  - In IDLE, `signal_out` is forced 1 and the counter is held at `HALF_SPACE-1`.
  - On entering START the counter runs, so the first toggle (1→0) comes `HALF_SPACE` cycles after START entry.
- `data_ready` is combinational: (state==IDLE || last cycle of final stop bit) && !`rst`.
- `data_valid` while not ready is ignored; the word is not latched.
- `busy` = state≠IDLE.
- Counter widths are $clog2 of the largest loaded value + 1; no wrap-around in normal use.

## Timing
- Reset values (cycle after `rst` sampled high): state IDLE, `signal_out`=1, `tone_sel`=1, `busy`=0, `frame_done`=0, `data_ready`=0 while `rst` high, tone counter=`HALF_MARK-1`, bit timer=0.
- Reset mid-frame aborts immediately with the values above. No partial frame completes.
- Handshake at edge T → `busy`=1 and `tone_sel`=0 from T+1.
- Frame length F = (1+`DATA_BITS`+(`PARITY`≠0)+`STOP_BITS`)·`BIT_CYCLES` cycles.
- `frame_done` is high in cycle T+F; IDLE (or the next START) from T+F+1.
- Back-to-back frames (handshake in the `frame_done` cycle) leave no idle gap.
- Every high/low interval of `signal_out` lasts exactly `HALF_MARK` or `HALF_SPACE` cycles. The only exception is the forced-high idle level when `IDLE_TONE`=0.

## Test plan
- Reset: assert `rst` 3 cycles mid-frame → next cycle `signal_out`=1, `busy`=0, `tone_sel`=1; `data_ready`=0 until `rst` low, then 1.
- Single frame (`BIT_CYCLES`=16, `DATA_BITS`=8, `PARITY`=1, `data_in`=0xA5) → `tone_sel` per 16-cycle bit is 0,1,0,1,0,0,1,0,1,0,1; `frame_done` pulses 176 cycles after the handshake.
- Phase continuity (`HALF_MARK`=2, `HALF_SPACE`=5, random words) → every `signal_out` run length ∈ {2,5}; edge count per bit matches the tone.
- Back-to-back: hold `data_valid`=1 with 0x00 then 0xFF → second START begins the cycle after the first `frame_done`, with `busy` never dropping.
- Ignored valid: pulse `data_valid` with 0x3C mid-frame → not latched; the next frame carries only a word offered while `data_ready`=1.
- `IDLE_TONE`=0, `PARITY`=2, `STOP_BITS`=2 → `signal_out` constant 1 in idle; first falling edge 8 cycles after START with `HALF_SPACE`=8; odd parity bit for 0x01 = 0; stop section 2·`BIT_CYCLES` of mark.
